// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: wait-state memory read, held response, decoded fields.
// Optional completion/error counters are built when IMEM_FETCH_COUNT_EN is defined.
module imem_fetch_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_pc,
  output logic        resp_err,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_ext,
  output logic [25:0] jaddr,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] fetch_cnt,
  output logic [31:0] err_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic [31:0] mem [DEPTH];

  logic [31:0] rd_addr;
  logic        rd_err;
  logic [31:0] rd_data;
  logic        unused_wr_lsb;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:DEPTH_LOG2+2] != '0);
  endfunction

  // In IDLE the read address comes straight from the request (zero wait states);
  // afterwards it comes from the latched PC.
  assign rd_addr = (state == S_IDLE) ? req_addr : resp_pc;
  assign rd_err  = addr_err(rd_addr);
  assign rd_data = rd_err ? 32'h0000_0000 : mem[rd_addr[DEPTH_LOG2+1:2]];

  assign req_ready     = (state == S_IDLE);
  assign resp_valid    = (state == S_RESP);
  assign unused_wr_lsb = ^wr_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      resp_instr <= 32'h0;
      resp_pc    <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            resp_pc  <= req_addr;
            wait_cnt <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              resp_instr <= rd_data;
              resp_err   <= rd_err;
              state      <= S_RESP;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            resp_instr <= rd_data;
            resp_err   <= rd_err;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Nonblocking write gives read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr[31:DEPTH_LOG2+2] == '0))
      mem[wr_addr[DEPTH_LOG2+1:2]] <= wr_data;
  end

  assign op      = resp_instr[31:26];
  assign rs      = resp_instr[25:21];
  assign rt      = resp_instr[20:16];
  assign rd      = resp_instr[15:11];
  assign imm_ext = {{16{resp_instr[15]}}, resp_instr[15:0]};
  assign jaddr   = resp_instr[25:0];

`ifdef IMEM_FETCH_COUNT_EN
  logic [31:0] fetch_q;
  logic [31:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= 32'h0;
      err_q   <= 32'h0;
    end else if (resp_valid && resp_ready) begin
      fetch_q <= fetch_q + 32'd1;
      if (resp_err) err_q <= err_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign err_cnt   = err_q;
`else
  assign fetch_cnt = 32'h0;
  assign err_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: vector table plus stall, reset, collision and counter sequences.
module tb_imem_fetch_responder;

  localparam int WS = 1;

  logic        clk;
  logic        rst;
  logic        req_valid, resp_ready, wr_en;
  logic [31:0] req_addr, wr_addr, wr_data;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_instr, resp_pc, imm_ext, fetch_cnt, err_cnt;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [25:0] jaddr;

  logic        req_valid0, resp_ready0, wr_en0;
  logic [31:0] req_addr0, wr_addr0, wr_data0;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_instr0, resp_pc0, imm_ext0, fetch_cnt0, err_cnt0;
  logic [5:0]  op0;
  logic [4:0]  rs0, rt0, rd0;
  logic [25:0] jaddr0;

  int checks = 0;
  int errors = 0;

  imem_fetch_responder #(.DEPTH_LOG2(8), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_pc(resp_pc), .resp_err(resp_err),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext), .jaddr(jaddr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_cnt(fetch_cnt), .err_cnt(err_cnt)
  );

  imem_fetch_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_instr(resp_instr0), .resp_pc(resp_pc0), .resp_err(resp_err0),
    .op(op0), .rs(rs0), .rt(rt0), .rd(rd0), .imm_ext(imm_ext0), .jaddr(jaddr0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .fetch_cnt(fetch_cnt0), .err_cnt(err_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [31:0] instr;
    logic        err;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [25:0] jaddr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_fetch(input logic [31:0] a, output int lat);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_fetch();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  int          lat;
  logic [31:0] held_instr, held_pc;
  logic [31:0] exp_fetch, exp_err;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid0 = 1'b0; req_addr0 = '0; resp_ready0 = 1'b0;
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;

    vecs[0] = '{32'h10,  1'b1, 32'h8C220004, 32'h8C220004, 1'b0, 6'h23, 5'd1, 5'd2,  5'd0,  32'h00000004, 26'h0220004};
    vecs[1] = '{32'h20,  1'b1, 32'h1000FFFC, 32'h1000FFFC, 1'b0, 6'h04, 5'd0, 5'd0,  5'd31, 32'hFFFFFFFC, 26'h000FFFC};
    vecs[2] = '{32'h20,  1'b1, 32'h08000040, 32'h08000040, 1'b0, 6'h02, 5'd0, 5'd0,  5'd0,  32'h00000040, 26'h0000040};
    vecs[3] = '{32'h3FC, 1'b1, 32'h012A4020, 32'h012A4020, 1'b0, 6'h00, 5'd9, 5'd10, 5'd8,  32'h00004020, 26'h12A4020};
    vecs[4] = '{32'h12,  1'b0, 32'h0,        32'h0,        1'b1, 6'h00, 5'd0, 5'd0,  5'd0,  32'h0,        26'h0};
    vecs[5] = '{32'h400, 1'b0, 32'h0,        32'h0,        1'b1, 6'h00, 5'd0, 5'd0,  5'd0,  32'h0,        26'h0};

    repeat (3) tick();
    rst = 1'b0;

    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_instr", resp_instr, 0);
    chk("rst_resp_pc", resp_pc, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) write_word(vecs[i].addr, vecs[i].data);
      start_fetch(vecs[i].addr, lat);
      chk($sformatf("v%0d_latency", i), lat, WS + 1);
      chk($sformatf("v%0d_instr", i), resp_instr, vecs[i].instr);
      chk($sformatf("v%0d_pc", i), resp_pc, vecs[i].addr);
      chk($sformatf("v%0d_err", i), resp_err, vecs[i].err);
      chk($sformatf("v%0d_op", i), op, vecs[i].op);
      chk($sformatf("v%0d_rs", i), rs, vecs[i].rs);
      chk($sformatf("v%0d_rt", i), rt, vecs[i].rt);
      chk($sformatf("v%0d_rd", i), rd, vecs[i].rd);
      chk($sformatf("v%0d_imm", i), imm_ext, vecs[i].imm);
      chk($sformatf("v%0d_jaddr", i), jaddr, vecs[i].jaddr);
      finish_fetch();
      chk($sformatf("v%0d_idle_ready", i), req_ready, 1);
    end

    // Stall: consumer holds resp_ready low for five cycles.
    req_valid = 1'b1; req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    chk("stall_wait_ready", req_ready, 0);
    chk("stall_wait_valid", resp_valid, 0);
    tick();
    held_instr = resp_instr;
    held_pc    = resp_pc;
    chk("stall_first_instr", held_instr, 32'h8C220004);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), resp_valid, 1);
      chk($sformatf("stall%0d_ready", c), req_ready, 0);
      chk($sformatf("stall%0d_instr", c), resp_instr, 32'h8C220004);
      chk($sformatf("stall%0d_pc", c), resp_pc, 32'h10);
      tick();
    end
    finish_fetch();
    chk("stall_release_ready", req_ready, 1);
    chk("stall_release_valid", resp_valid, 0);

    // Write at the accept edge lands before the read edge.
    write_word(32'h30, 32'hAAAA0000);
    req_valid = 1'b1; req_addr = 32'h30;
    wr_en = 1'b1; wr_addr = 32'h30; wr_data = 32'h00005555;
    tick();
    req_valid = 1'b0; wr_en = 1'b0;
    tick();
    chk("wait_wr_valid", resp_valid, 1);
    chk("wait_wr_instr", resp_instr, 32'h00005555);
    finish_fetch();

    // Reset during WAIT discards the request.
    req_valid = 1'b1; req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    chk("rstwait_in_wait", req_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstwait_ready", req_ready, 1);
    chk("rstwait_instr", resp_instr, 0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rstwait%0d_novalid", c), resp_valid, 0);
      tick();
    end

    // Zero-wait-state instance: same-edge write and read return old data.
    wr_en0 = 1'b1; wr_addr0 = 32'h20; wr_data0 = 32'h11111111;
    tick();
    wr_en0 = 1'b0;
    req_valid0 = 1'b1; req_addr0 = 32'h20;
    wr_en0 = 1'b1; wr_data0 = 32'h22222222;
    tick();
    req_valid0 = 1'b0; wr_en0 = 1'b0;
    chk("rbw_valid", resp_valid0, 1);
    chk("rbw_old_data", resp_instr0, 32'h11111111);
    resp_ready0 = 1'b1;
    tick();
    resp_ready0 = 1'b0;
    req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    chk("rbw_new_data", resp_instr0, 32'h22222222);
    resp_ready0 = 1'b1;
    tick();
    resp_ready0 = 1'b0;

    // Counters: three good fetches and one misaligned one from a clean reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_fetch(32'h10, lat);  finish_fetch();
    start_fetch(32'h20, lat);  finish_fetch();
    start_fetch(32'h3FC, lat); finish_fetch();
    start_fetch(32'h12, lat);  finish_fetch();
`ifdef IMEM_FETCH_COUNT_EN
    exp_fetch = 32'd4;
    exp_err   = 32'd1;
`else
    exp_fetch = 32'd0;
    exp_err   = 32'd0;
`endif
    chk("cnt_fetch", fetch_cnt, exp_fetch);
    chk("cnt_err", err_cnt, exp_err);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_fetch_rst", fetch_cnt, 0);
    chk("cnt_err_rst", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
